video_timing_gen: RTL

Parametrised raster timing generator for the StarSoC display path and successor to the fixed 640x480 HDMI timing block. From the system clock it produces a pixel-rate strobe, pixel coordinates, sync pulses and blanking, for any resolution, porch layout, sync polarity or clock ratio set by parameters. It adds a run/stop control that only starts or stops on frame boundaries, plus line-start and frame-start strobes for the game logic and framebuffer reader.

---
 rtl/video_timing_pkg.sv | 40 ++++
 rtl/video_timing_gen_px_divider.sv | 43 ++++
 rtl/video_timing_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared types for the raster timing generator:
// video mode bundle, stock modes and FSM states.
package video_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } video_mode_t;

  localparam video_mode_t MODE_640x480 = '{
    h_active: 16'd640, h_fp: 16'd16,
    h_sync:   16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10,
    v_sync:   16'd2,   v_bp: 16'd33,
    hs_pol:   1'b0,    vs_pol: 1'b0
  };

  localparam video_mode_t MODE_800x600 = '{
    h_active: 16'd800, h_fp: 16'd40,
    h_sync:   16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,
    v_sync:   16'd4,   v_bp: 16'd23,
    hs_pol:   1'b1,    vs_pol: 1'b1
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vt_state_e;

endpackage

// File: rtl/video_timing_gen_px_divider.sv
// Pixel-rate divider: div_cnt counts 0..CLK_DIV-1 while run is high.
// Ports: clk, reset (sync, active-low), run, pix_tick (registered).
module px_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic pix_tick
);
  import video_timing_pkg::*;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          run_q;
  logic          pix_tick_q, pix_tick_d;

  // run is the next-cycle run state, so a fresh start
  // (run high, run_q low) restarts the count at 0.
  always_comb begin
    div_cnt_d = '0;
    if (run && run_q && div_cnt_q != LAST)
      div_cnt_d = div_cnt_q + 1'b1;
    pix_tick_d = run && (div_cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q  <= '0;
      run_q      <= 1'b0;
      pix_tick_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      run_q      <= run;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with frame-aligned run/stop control.
// Ports: clk, reset (sync, active-low), enable -> x, y, syncs, strobes.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] y,
  output logic hsync,
  output logic vsync,
  output logic video_on,
  output logic pix_tick,
  output logic line_start,
  output logic frame_start,
  output logic running
);
  import video_timing_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_B   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_E   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_B   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_E   = YW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CLK_DIV < 1) begin : g_bad_param
    $error("video_timing_gen: widths and CLK_DIV must be >= 1");
  end

  vt_state_e     state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          running_q, running_d;
  logic          tick;
  logic          run;
  logic          start;
  logic          wrap_x, wrap_f;

  px_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .pix_tick (tick)
  );

  // tick is high during the cycle whose closing edge
  // advances the counters.
  always_comb begin
    wrap_x = tick && (x_q == X_LAST);
    wrap_f = wrap_x && (y_q == Y_LAST);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)      state_d = RUN;
        else if (wrap_f) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    run   = (state_d != IDLE);
    start = run && (state_q == IDLE);

    x_d = x_q;
    y_d = y_q;
    if (!run) begin
      x_d = '0;
      y_d = '0;
    end else if (tick) begin
      x_d = wrap_x ? '0 : x_q + 1'b1;
      if (wrap_x)
        y_d = wrap_f ? '0 : y_q + 1'b1;
    end

    line_start_d  = start || (run && wrap_x);
    frame_start_d = start || (run && wrap_f);
    running_d     = run;

    hsync_d = (run && x_d >= HS_B && x_d < HS_E) ?
              HS_POL : ~HS_POL;
    vsync_d = (run && y_d >= VS_B && y_d < VS_E) ?
              VS_POL : ~VS_POL;
    video_on_d = run && (x_d < X_ACT) && (y_d < Y_ACT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_tick    = tick;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule
